// File: rtl/params_pkg.sv
// Shared core parameters plus the reorder-buffer entry and completion-port types.
package params_pkg;

  localparam int REGISTER_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int ROB_ENTRIES    = 8;
  localparam int ROB_IDX_W      = $clog2(ROB_ENTRIES);

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      reg_wr_en;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
  } rob_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [ROB_IDX_W-1:0]  idx;
    logic [DATA_WIDTH-1:0] data;
  } rob_done_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: decode allocates tags at the tail, execution units
// complete by tag in any order, the head retires one completed entry per cycle.
module reorder_buffer
  import params_pkg::*;
#(
  parameter int ROB_ENTRIES    = params_pkg::ROB_ENTRIES,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
  localparam int IDX_W         = $clog2(ROB_ENTRIES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      alloc_valid_i,
  input  logic                      alloc_reg_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0] alloc_wr_reg_i,
  output logic [IDX_W-1:0]          alloc_idx_o,
  output logic                      rob_is_full_o,
  output logic                      rob_empty_o,
  input  logic                      alu_done_valid_i,
  input  logic [IDX_W-1:0]          alu_done_idx_i,
  input  logic [DATA_WIDTH-1:0]     alu_done_data_i,
  input  logic                      ex_done_valid_i,
  input  logic [IDX_W-1:0]          ex_done_idx_i,
  input  logic [DATA_WIDTH-1:0]     ex_done_data_i,
  input  logic                      mem_done_valid_i,
  input  logic [IDX_W-1:0]          mem_done_idx_i,
  input  logic [DATA_WIDTH-1:0]     mem_done_data_i,
  output logic                      commit_valid_o,
  output logic                      commit_reg_wr_en_o,
  output logic [REGISTER_WIDTH-1:0] commit_wr_reg_o,
  output logic [DATA_WIDTH-1:0]     commit_data_o
);

  localparam int NUM_DONE = 3;

  // Local mirrors of the package types so overridden widths stay consistent.
  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      reg_wr_en;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     data;
  } entry_t;

  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] data;
  } done_t;

  entry_t           ent_q [ROB_ENTRIES];
  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;
  done_t            dn [NUM_DONE];
  logic             alloc_fire, commit_fire;

  always_comb begin
    dn[0] = '{valid: alu_done_valid_i, idx: alu_done_idx_i, data: alu_done_data_i};
    dn[1] = '{valid: ex_done_valid_i,  idx: ex_done_idx_i,  data: ex_done_data_i};
    dn[2] = '{valid: mem_done_valid_i, idx: mem_done_idx_i, data: mem_done_data_i};
  end

  assign rob_is_full_o = (count_q == (IDX_W+1)'(ROB_ENTRIES));
  assign rob_empty_o   = (count_q == '0);
  assign alloc_idx_o   = tail_q;

  // A same-cycle commit does not open a slot for allocation: full is registered.
  assign alloc_fire  = alloc_valid_i && !rob_is_full_o && !flush_i;
  assign commit_fire = ent_q[head_q].valid && ent_q[head_q].done && !flush_i;

  assign commit_valid_o     = commit_fire;
  assign commit_reg_wr_en_o = commit_fire && ent_q[head_q].reg_wr_en;
  assign commit_wr_reg_o    = ent_q[head_q].wr_reg;
  assign commit_data_o      = ent_q[head_q].data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) ent_q[i] <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) ent_q[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_DONE; p++) begin
        if (dn[p].valid && ent_q[dn[p].idx].valid) begin
          ent_q[dn[p].idx].done <= 1'b1;
          ent_q[dn[p].idx].data <= dn[p].data;
        end
      end
      if (commit_fire) begin
        ent_q[head_q].valid <= 1'b0;
        ent_q[head_q].done  <= 1'b0;
        head_q              <= head_q + IDX_W'(1);
      end
      // The tail slot is never valid here, so no completion above can target it.
      if (alloc_fire) begin
        ent_q[tail_q] <= '{valid: 1'b1, done: 1'b0, reg_wr_en: alloc_reg_wr_en_i,
                           wr_reg: alloc_wr_reg_i, data: '0};
        tail_q        <= tail_q + IDX_W'(1);
      end
      count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
    end
  end

  // Completion ports must target distinct, live entries.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int p = 0; p < NUM_DONE; p++) begin
        assert (!(dn[p].valid && !ent_q[dn[p].idx].valid));
        for (int q = p + 1; q < NUM_DONE; q++)
          assert (!(dn[p].valid && dn[q].valid && dn[p].idx == dn[q].idx));
      end
    end
  end

endmodule
